// File: rtl/pc_next_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : pc_next_ctrl_if
// Brief  : Control/LUT/status bundle between the core and pc_next_ctrl.
//          taken_count exists only when PC_TAKEN_COUNT_EN is defined.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pc_next_ctrl_if #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4
);
    logic              start;
    logic              stall;
    logic              halt;
    logic              branch;
    logic [7:0]        alu_out;
    logic [LUT_AW-1:0] lut_idx;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    logic [PC_W-1:0]   lut_wdata;
    logic [PC_W-1:0]   pc;
    logic              running;
    logic              done;
    logic              taken;
`ifdef PC_TAKEN_COUNT_EN
    logic [15:0]       taken_count;
`endif

    modport master (
        output start, stall, halt, branch, alu_out, lut_idx,
               lut_we, lut_waddr, lut_wdata,
`ifdef PC_TAKEN_COUNT_EN
        input  taken_count,
`endif
        input  pc, running, done, taken
    );

    modport slave (
        input  start, stall, halt, branch, alu_out, lut_idx,
               lut_we, lut_waddr, lut_wdata,
`ifdef PC_TAKEN_COUNT_EN
        output taken_count,
`endif
        output pc, running, done, taken
    );
endinterface

`default_nettype wire

// File: rtl/pc_next_ctrl.sv
//------------------------------------------------------------------------------
// Module : pc_next_ctrl
// Brief  : Program counter / next-PC selection with branch-target LUT and
//          IDLE/RUN/DONE sequencing. Optional macro: PC_TAKEN_COUNT_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_next_ctrl #(
    parameter int PC_W     = 10,
    parameter int LUT_AW   = 4,
    parameter int START_PC = 0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    pc_next_ctrl_if.slave   bus
);
    localparam int              c_lut_n    = 2 ** LUT_AW;
    localparam logic [PC_W-1:0] c_start_pc = PC_W'(START_PC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic            r_taken;
    logic            w_taken_nxt;
    logic            r_running;
    logic            r_done;
    logic            w_start_acc;
    logic [PC_W-1:0] r_lut [c_lut_n];
    logic            w_unused_alu;

    assign w_unused_alu = ^bus.alu_out[7:1];

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_taken_nxt = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = c_start_pc;
                end
            end
            ST_RUN: begin
                // stall outranks halt, halt outranks a taken branch
                if (bus.stall) begin
                    w_state_nxt = ST_RUN;
                end else if (bus.halt) begin
                    w_state_nxt = ST_DONE;
                end else if (bus.branch && bus.alu_out[0]) begin
                    w_pc_nxt    = r_lut[bus.lut_idx];
                    w_taken_nxt = 1'b1;
                end else begin
                    w_pc_nxt    = r_pc + PC_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= c_start_pc;
            r_taken   <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_taken   <= w_taken_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    // Async read above sees the pre-edge contents, so a same-cycle write
    // to the branch entry yields the old target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_lut_n; i++) begin
                r_lut[i] <= '0;
            end
        end else if (bus.lut_we) begin
            r_lut[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

`ifdef PC_TAKEN_COUNT_EN
    logic [15:0] r_taken_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_count <= 16'h0000;
        end else if (w_start_acc) begin
            r_taken_count <= 16'h0000;
        end else if (w_taken_nxt && (r_taken_count != 16'hFFFF)) begin
            r_taken_count <= r_taken_count + 16'h0001;
        end
    end

    assign bus.taken_count = r_taken_count;
`endif

    assign bus.pc      = r_pc;
    assign bus.running = r_running;
    assign bus.done    = r_done;
    assign bus.taken   = r_taken;

endmodule

`default_nettype wire

// File: tb/tb_pc_next_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_pc_next_ctrl
// Brief  : Scoreboard bench for pc_next_ctrl (honours PC_TAKEN_COUNT_EN).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_next_ctrl;
    localparam int PC_W   = 10;
    localparam int LUT_AW = 4;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            running;
        logic            done;
        logic            taken;
        logic [15:0]     cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    exp_t            sb[$];
    int              m_state;
    logic [PC_W-1:0] m_pc;
    logic            m_taken;
    logic [15:0]     m_cnt;
    logic [PC_W-1:0] m_lut [2**LUT_AW];

    pc_next_ctrl_if #(.PC_W(PC_W), .LUT_AW(LUT_AW)) bus ();

    pc_next_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW), .START_PC(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = '0;
        m_taken = 1'b0;
        m_cnt   = 16'h0;
        for (int i = 0; i < 2**LUT_AW; i++) m_lut[i] = '0;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.stall = 0; bus.halt = 0; bus.branch = 0;
        bus.alu_out = 8'h00; bus.lut_idx = '0;
        bus.lut_we = 0; bus.lut_waddr = '0; bus.lut_wdata = '0;
    endtask

    // One clock: predict from the current inputs, push, clock, pop and compare.
    task automatic step();
        exp_t e;
        int   ns;
        ns = m_state;
        e.pc = m_pc; e.taken = 1'b0; e.cnt = m_cnt;
        if (m_state != 1) begin
            if (bus.start) begin ns = 1; e.pc = '0; e.cnt = 16'h0; end
        end else if (bus.stall) begin
        end else if (bus.halt) begin
            ns = 2;
        end else if (bus.branch && bus.alu_out[0]) begin
            e.pc = m_lut[bus.lut_idx];
            e.taken = 1'b1;
            if (m_cnt != 16'hFFFF) e.cnt = m_cnt + 16'h1;
        end else begin
            e.pc = m_pc + 10'd1;
        end
        e.running = (ns == 1);
        e.done    = (ns == 2);
        if (bus.lut_we) m_lut[bus.lut_waddr] = bus.lut_wdata;
        m_state = ns; m_pc = e.pc; m_taken = e.taken; m_cnt = e.cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("pc",      32'(bus.pc),      32'(e.pc));
            check("running", 32'(bus.running), 32'(e.running));
            check("done",    32'(bus.done),    32'(e.done));
            check("taken",   32'(bus.taken),   32'(e.taken));
`ifdef PC_TAKEN_COUNT_EN
            check("taken_count", 32'(bus.taken_count), 32'(e.cnt));
`endif
        end
        idle_inputs();
    endtask

    task automatic do_branch(input logic [3:0] idx, input logic [7:0] alu);
        bus.branch = 1; bus.lut_idx = idx; bus.alu_out = alu;
        step();
    endtask

    task automatic lut_write(input logic [3:0] a, input logic [PC_W-1:0] d);
        bus.lut_we = 1; bus.lut_waddr = a; bus.lut_wdata = d;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #12;
        check("rst_pc",      32'(bus.pc),      32'h0);
        check("rst_running", 32'(bus.running), 32'h0);
        check("rst_done",    32'(bus.done),    32'h0);
        check("rst_taken",   32'(bus.taken),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step();                                // IDLE holds without start
        lut_write(4'd3, 10'h040);              // write accepted in IDLE
        bus.start = 1; step();
        for (int i = 0; i < 5; i++) step();
        check("pc_seq_end", 32'(bus.pc), 32'h5);

        do_branch(4'd3, 8'h01);
        check("br_taken_pc", 32'(bus.pc), 32'h040);
        do_branch(4'd3, 8'hFE);
        check("br_not_taken_pc", 32'(bus.pc), 32'h041);

        lut_write(4'd5, 10'h3FE);
        do_branch(4'd5, 8'h03);
        step();
        check("pc_max", 32'(bus.pc), 32'h3FF);
        step();
        check("pc_wrap", 32'(bus.pc), 32'h000);

        // stall freezes everything even with halt/branch, LUT still writable
        bus.stall = 1; bus.halt = 1; bus.branch = 1; bus.lut_idx = 4'd3;
        bus.alu_out = 8'h01; bus.lut_we = 1; bus.lut_waddr = 4'd7; bus.lut_wdata = 10'h055;
        step();
        check("stall_pc", 32'(bus.pc), 32'h000);
        do_branch(4'd7, 8'h01);
        check("stall_lut_wr", 32'(bus.pc), 32'h055);

        bus.start = 1; step();                 // ignored in RUN
        check("start_in_run", 32'(bus.pc), 32'h056);

        lut_write(4'd6, 10'h012);
        do_branch(4'd6, 8'h01);
        bus.halt = 1; bus.branch = 1; bus.lut_idx = 4'd3; bus.alu_out = 8'h01;
        step();
        check("halt_pc", 32'(bus.pc), 32'h012);
        check("halt_done", 32'(bus.done), 32'h1);
        step();                                // DONE holds
        bus.start = 1; step();
        check("restart_pc", 32'(bus.pc), 32'h0);

        // same-cycle write and read of entry 3 returns the old target
        bus.branch = 1; bus.lut_idx = 4'd3; bus.alu_out = 8'h01;
        bus.lut_we = 1; bus.lut_waddr = 4'd3; bus.lut_wdata = 10'h100;
        step();
        check("rw_same_old", 32'(bus.pc), 32'h040);
        do_branch(4'd3, 8'h01);
        check("rw_same_new", 32'(bus.pc), 32'h100);

        bus.start = 1; step();                 // still RUN: no effect
        do_branch(4'd6, 8'h01);
        do_branch(4'd6, 8'h00);
        do_branch(4'd7, 8'hFF);
        do_branch(4'd7, 8'h80);
        do_branch(4'd3, 8'h01);
`ifdef PC_TAKEN_COUNT_EN
        check("cnt_3", 32'(bus.taken_count), 32'd3 + 32'd2);
`endif
        bus.halt = 1; step();
        bus.start = 1; step();
`ifdef PC_TAKEN_COUNT_EN
        check("cnt_start_clr", 32'(bus.taken_count), 32'd0);
        do_branch(4'd6, 8'h01); do_branch(4'd6, 8'h01); do_branch(4'd6, 8'h01);
        do_branch(4'd6, 8'h00); do_branch(4'd6, 8'h02);
        check("cnt_3of5", 32'(bus.taken_count), 32'd3);
`endif
        do_branch(4'd3, 8'h01);

        // asynchronous reset mid-RUN, away from any edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc",      32'(bus.pc),      32'h0);
        check("arst_running", 32'(bus.running), 32'h0);
        check("arst_taken",   32'(bus.taken),   32'h0);
        check("arst_done",    32'(bus.done),    32'h0);
`ifdef PC_TAKEN_COUNT_EN
        check("arst_cnt", 32'(bus.taken_count), 32'h0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1; step();
        do_branch(4'd3, 8'h01);                // LUT cleared by reset
        check("arst_lut_clr", 32'(bus.pc), 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got=running expected=finished");
        $fatal(1);
    end
endmodule

`default_nettype wire
